// File: rtl/charge_pkg.sv
// Shared constants for the charge session timer: FSM states, paid credit
// codes, unit decode and BCD helper.
package charge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHARGE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CODE_PAID_MIN  = 4'd5;
  localparam logic [3:0] CODE_PAID_MAX  = 4'd8;
  // Code 5 means one unit, so units = code - 4.
  localparam logic [3:0] UNIT_CODE_BASE = 4'd4;

  localparam int MIN_PER_UNIT_DEF = 1;
  localparam int SEC_MODULUS      = 60;
  localparam int MIN_MODULUS      = 100;

  function automatic logic is_paid(input logic [3:0] code);
    return (code >= CODE_PAID_MIN) && (code <= CODE_PAID_MAX);
  endfunction

  function automatic logic [2:0] code_units(input logic [3:0] code);
    logic [3:0] d;
    d = code - UNIT_CODE_BASE;
    return d[2:0];
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with selectable modulus (60 or 100); wraps
// 00 -> MODULUS-1 and flags the wrap on borrow in the same cycle.
module bcd_down_counter #(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] value,
  output logic       borrow
);

  localparam int         TOP_INT = MODULUS - 1;
  localparam logic [3:0] TOP_HI  = 4'(TOP_INT / 10);
  localparam logic [3:0] TOP_LO  = 4'(TOP_INT % 10);

  assign borrow = en && (value == 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      if (value[3:0] != 4'd0)
        value <= {value[7:4], value[3:0] - 4'd1};
      else if (value[7:4] != 4'd0)
        value <= {value[7:4] - 4'd1, 4'd9};
      else
        value <= {TOP_HI, TOP_LO};
    end
  end

endmodule

// File: rtl/charge_timer.sv
// Paid charging session timer: loads units*MIN_PER_UNIT minutes and counts
// mm:ss down on second ticks. Define CHARGE_REFUND_EN to add the refund output.
//
// state     | meaning
// ST_IDLE   | no session, display 00:00, waiting for a paid code
// ST_LOAD   | one cycle, counters loaded with the purchased time
// ST_CHARGE | on=1, counting down on each tick
// ST_DONE   | session over, wait for the code to leave the paid range
module charge_timer
  import charge_pkg::*;
#(
  parameter int MIN_PER_UNIT = MIN_PER_UNIT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [3:0] credit_code,
  input  logic       stop,
  output logic       on,
  output logic       done,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
`ifdef CHARGE_REFUND_EN
  ,
  output logic [2:0] refund
`endif
);

  state_t     state;
  logic [2:0] units;
  logic       paid;
  logic       dec;
  logic       expire;
  logic       cnt_load;
  logic [7:0] min_load_val;
  logic       sec_borrow;
  logic       min_borrow;

  assign paid = is_paid(credit_code);
  assign dec  = (state == ST_CHARGE) && tick && !stop;
  // min_borrow only fires on a tick at 00:00, which cannot happen; treat it as expiry anyway.
  assign expire = dec && (((min_bcd == 8'h00) && (sec_bcd == 8'h01)) || min_borrow);
  assign cnt_load = (state == ST_LOAD) || ((state == ST_DONE) && !paid);
  assign min_load_val = (state == ST_LOAD) ? to_bcd(7'(units) * 7'(MIN_PER_UNIT)) : 8'h00;

  bcd_down_counter #(.MODULUS(SEC_MODULUS)) u_sec (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (8'h00),
    .en       (dec),
    .value    (sec_bcd),
    .borrow   (sec_borrow)
  );

  bcd_down_counter #(.MODULUS(MIN_MODULUS)) u_min (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (min_load_val),
    .en       (sec_borrow),
    .value    (min_bcd),
    .borrow   (min_borrow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      units <= 3'd0;
      on    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (paid) begin
            units <= code_units(credit_code);
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          on    <= 1'b1;
          state <= ST_CHARGE;
        end
        ST_CHARGE: begin
          if (stop || expire) begin
            on    <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!paid)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CHARGE_REFUND_EN
  localparam logic [10:0] UNIT_SECS = 11'(MIN_PER_UNIT * 60);

  logic [2:0]  units_left;
  logic [10:0] unit_sec;

  // unit_sec tracks seconds left in the current unit; units_left counts the
  // current unit plus those not yet started.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      units_left <= 3'd0;
      unit_sec   <= 11'd0;
      refund     <= 3'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          units_left <= units;
          unit_sec   <= UNIT_SECS;
        end
        ST_CHARGE: begin
          if (stop) begin
            refund <= units_left - 3'd1;
          end else if (dec) begin
            if (expire)
              refund <= 3'd0;
            if (unit_sec == 11'd1) begin
              unit_sec   <= UNIT_SECS;
              units_left <= units_left - 3'd1;
            end else begin
              unit_sec <= unit_sec - 11'd1;
            end
          end
        end
        ST_DONE: begin
          if (!paid)
            refund <= 3'd0;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_charge_timer.sv
// Self-checking bench for charge_timer: directed scenarios plus random
// stimulus against a seconds-based reference model.
module tb_charge_timer;

  localparam int MPU       = 1;
  localparam int UNIT_S    = MPU * 60;
  localparam int M_IDLE    = 0;
  localparam int M_LOAD    = 1;
  localparam int M_CHARGE  = 2;
  localparam int M_DONE    = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] credit_code = 4'd0;
  logic       stop = 1'b0;
  logic       on;
  logic       done;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
`ifdef CHARGE_REFUND_EN
  logic [2:0] refund;
`endif

  charge_timer #(.MIN_PER_UNIT(MPU)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .credit_code (credit_code),
    .stop        (stop),
    .on          (on),
    .done        (done),
    .min_bcd     (min_bcd),
    .sec_bcd     (sec_bcd)
`ifdef CHARGE_REFUND_EN
    ,
    .refund      (refund)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: session tracked as whole remaining seconds.
  int m_mode   = M_IDLE;
  int m_rem    = 0;
  int m_units  = 0;
  int m_on     = 0;
  int m_done   = 0;
  int m_refund = 0;
  bit in_reset = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) * 16) + (v % 10);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_units = 0;
    m_on = 0; m_done = 0; m_refund = 0;
  endtask

  task automatic model_step(input logic t, input logic s, input logic [3:0] c);
    bit paid;
    paid = (c >= 4'd5) && (c <= 4'd8);
    m_done = 0;
    if (in_reset) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: if (paid) begin m_units = int'(c) - 4; m_mode = M_LOAD; end
      M_LOAD: begin m_rem = m_units * UNIT_S; m_on = 1; m_mode = M_CHARGE; end
      M_CHARGE: begin
        if (s) begin
          m_refund = (m_rem + UNIT_S - 1) / UNIT_S - 1;
          m_mode = M_DONE; m_on = 0; m_done = 1;
        end else if (t) begin
          m_rem--;
          if (m_rem == 0) begin
            m_refund = 0; m_mode = M_DONE; m_on = 0; m_done = 1;
          end
        end
      end
      default: if (!paid) begin m_mode = M_IDLE; m_rem = 0; m_refund = 0; end
    endcase
  endtask

  task automatic compare_all();
    check("on", 32'(on), 32'(m_on));
    check("done", 32'(done), 32'(m_done));
    check("min_bcd", 32'(min_bcd), 32'(bcd(m_rem / 60)));
    check("sec_bcd", 32'(sec_bcd), 32'(bcd(m_rem % 60)));
`ifdef CHARGE_REFUND_EN
    check("refund", 32'(refund), 32'(m_refund));
`endif
  endtask

  task automatic cycle(input logic t, input logic s, input logic [3:0] c);
    tick = t; stop = s; credit_code = c;
    @(posedge clk);
    model_step(t, s, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_ticks(input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, c);
  endtask

  int done_cnt;

  initial begin
    model_reset();
    @(negedge clk);
    check("rst_on", 32'(on), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_min", 32'(min_bcd), 32'h00);
    check("rst_sec", 32'(sec_bcd), 32'h00);
    #1 reset_n = 1'b1;
    in_reset = 1'b0;
    cycle(1'b0, 1'b0, 4'd0);

    // One unit, natural expiry
    cycle(1'b0, 1'b0, 4'd5);
    check("r26_load_on", 32'(on), 32'd0);
    cycle(1'b0, 1'b0, 4'd5);
    check("r26_start_on", 32'(on), 32'd1);
    check("r26_start_min", 32'(min_bcd), 32'h01);
    check("r26_start_sec", 32'(sec_bcd), 32'h00);
    cycle(1'b1, 1'b0, 4'd5);
    check("r26_59", 32'({min_bcd, sec_bcd}), 32'h0059);
    done_cnt = 0;
    for (int i = 0; i < 59; i++) begin
      cycle(1'b1, 1'b0, 4'd5);
      if (done) done_cnt++;
    end
    check("r26_end", 32'({min_bcd, sec_bcd}), 32'h0000);
    check("r26_end_on", 32'(on), 32'd0);
    cycle(1'b1, 1'b0, 4'd0);
    if (done) done_cnt++;
    check("r26_done_cnt", 32'(done_cnt), 32'd1);

    // Four units
    cycle(1'b0, 1'b0, 4'd8);
    cycle(1'b0, 1'b0, 4'd8);
    check("r27_start", 32'({min_bcd, sec_bcd}), 32'h0400);
    cycle(1'b1, 1'b0, 4'd8);
    check("r27_first", 32'({min_bcd, sec_bcd}), 32'h0359);
    run_ticks(59, 4'd8);
    check("r27_60", 32'({min_bcd, sec_bcd}), 32'h0300);
    cycle(1'b0, 1'b1, 4'd8);
    cycle(1'b0, 1'b0, 4'd0);

    // Three units, stopped after 30 s
    cycle(1'b0, 1'b0, 4'd7);
    cycle(1'b0, 1'b0, 4'd7);
    run_ticks(30, 4'd7);
    cycle(1'b0, 1'b1, 4'd7);
    check("r28_frozen", 32'({min_bcd, sec_bcd}), 32'h0230);
    check("r28_on", 32'(on), 32'd0);
    check("r28_done", 32'(done), 32'd1);
`ifdef CHARGE_REFUND_EN
    check("r28_refund", 32'(refund), 32'd2);
`endif
    cycle(1'b1, 1'b1, 4'd7);
    check("r28_hold", 32'({min_bcd, sec_bcd}), 32'h0230);
    cycle(1'b0, 1'b0, 4'd0);

    // Reset mid-session at 01:15
    cycle(1'b0, 1'b0, 4'd6);
    cycle(1'b0, 1'b0, 4'd6);
    run_ticks(45, 4'd6);
    check("r29_pre", 32'({min_bcd, sec_bcd}), 32'h0115);
    #2 reset_n = 1'b0;
    #1;
    check("r29_async_on", 32'(on), 32'd0);
    check("r29_async_disp", 32'({min_bcd, sec_bcd}), 32'h0000);
    in_reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'd6);
    check("r29_held", 32'({on, min_bcd, sec_bcd}), 32'h0);
    credit_code = 4'd0;
    #1 reset_n = 1'b1;
    in_reset = 1'b0;
    cycle(1'b0, 1'b0, 4'd0);

    // Expiry with code held paid, then restart
    cycle(1'b0, 1'b0, 4'd8);
    cycle(1'b0, 1'b0, 4'd8);
    run_ticks(240, 4'd8);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'd8);
    check("r30_hold_on", 32'(on), 32'd0);
    check("r30_hold_disp", 32'({min_bcd, sec_bcd}), 32'h0000);
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd5);
    cycle(1'b0, 1'b0, 4'd5);
    check("r30_restart", 32'({min_bcd, sec_bcd}), 32'h0100);

    // tick and stop together at 00:45
    run_ticks(15, 4'd5);
    check("r31_pre", 32'({min_bcd, sec_bcd}), 32'h0045);
    cycle(1'b1, 1'b1, 4'd5);
    check("r31_disp", 32'({min_bcd, sec_bcd}), 32'h0045);
    check("r31_done", 32'(done), 32'd1);
    cycle(1'b0, 1'b0, 4'd0);

    // Random phase
    begin
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 59) == 0) c = 4'($urandom_range(0, 15));
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 149) == 0), c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/charge_timer.md
CHARGE_TIMER -- requirements
Module: charge_timer

Interface
REQ-001 SHALL have parameter MIN_PER_UNIT, default 1: charging minutes granted per paid unit of 5; legal range 1..24.
REQ-002 SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port tick, input, 1 bit: one-clk pulse per elapsed second, from an external prescaler.
REQ-005 SHALL have port credit_code, input, 4 bits: payment-FSM state code; 5/6/7/8 = paid 5/10/15/20, i.e. 1/2/3/4 units; any other value = not paid.
REQ-006 SHALL have port stop, input, 1 bit: user abort, level, synchronous.
REQ-007 SHALL have port on, output, 1 bit: charging active; returned to the payment FSM.
REQ-008 SHALL have port done, output, 1 bit: one-clk pulse when a session ends.
REQ-009 SHALL have port min_bcd, output, 8 bits: remaining minutes as two BCD digits.
REQ-010 SHALL have port sec_bcd, output, 8 bits: remaining seconds as two BCD digits.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> CHARGE -> DONE -> IDLE; all outputs registered.
REQ-012 In IDLE: on=0 and display 00:00; a paid credit_code (5..8) sampled at a clk edge SHALL move to LOAD.
REQ-013 In LOAD (1 cycle): SHALL load min_bcd = units*MIN_PER_UNIT in BCD, sec_bcd=00, then enter CHARGE; on=1 from the cycle after LOAD.
REQ-014 In CHARGE, each tick SHALL decrement mm:ss once: ss 00 borrows to 59 with mm-1; BCD digits never leave 0..9 / 0..5.
REQ-015 A tick at 00:01 SHALL give 00:00, DONE, on=0 and a done pulse, all in the same following cycle.
REQ-016 stop in CHARGE SHALL enter DONE next cycle; display frozen at current value; done pulsed.
REQ-017 stop and tick in the same cycle: stop SHALL win; no decrement.
REQ-018 In DONE: on=0; SHALL hold until credit_code is outside 5..8, then IDLE (display cleared to 00:00); no restart while the code remains paid.
REQ-019 tick, stop and credit_code changes in IDLE/LOAD/DONE other than per REQ-012/018 SHALL be ignored.

Reset
REQ-020 On reset_n=0: SHALL be in IDLE immediately (async), with on=0, done=0, min_bcd=00, sec_bcd=00, refund=0.
REQ-021 A reset mid-CHARGE SHALL abandon the session; after release it SHALL restart only via REQ-012.

Configuration
REQ-022 Macro CHARGE_REFUND_EN defined: SHALL add output refund, 3 bits = units not yet started at session end (units_left-1 on stop; 0 on natural expiry); valid from the done pulse until IDLE; unit bookkeeping counter included.
REQ-023 Macro absent: SHALL omit the refund port and unit counter entirely; all other behaviour identical.

Structure
REQ-024 SHALL place FSM state encodings, paid credit codes 5..8, the unit-decode constants and the MIN_PER_UNIT default in shared package charge_pkg.
REQ-025 SHALL use one sub-module, bcd_down_counter: two-digit BCD down counter with modulus (60 or 100), load, enable and borrow-out; instantiated for seconds and minutes.

Verification (MIN_PER_UNIT=1)
REQ-026 credit_code=5, then 60 ticks: on=1 from LOAD+1, display 01:00 -> 00:59 -> ... -> 00:00; on=0 and one done pulse.
REQ-027 credit_code=8, 1 tick: display 04:00 -> 03:59; after 60 ticks total, display 03:00.
REQ-028 credit_code=7, 30 ticks, then stop: display frozen at 02:30, on=0, done pulse; refund=2 with CHARGE_REFUND_EN.
REQ-029 reset_n low at 01:15 during credit_code=6: on=0, display 00:00 immediately; no reload while reset_n is held.
REQ-030 Natural expiry with credit_code held at 8: stays DONE, on=0; credit_code -> 0 gives IDLE next cycle; credit_code -> 5 then starts a new session at 01:00.
REQ-031 tick and stop asserted in the same cycle at 00:45: display stays 00:45, DONE entered.
